vga_board_render: RTL and testbench

- Parametrised Connect-4 board renderer: generalises the fixed 7x6 board display to any COLS x ROWS grid, pitch and piece radius.
- Converts pixel counters into a slot address for the board-state store and consumes slot state one cycle later.
- Adds a two-stage registered pixel pipeline, true circle tests and blinking of winning pieces.
- Sits between the VGA timing generator and the RGB pins; the game FSM owns the board-state store.

---
 rtl/vga_board_render.sv | 166 ++++++++++++++++
 tb/tb_vga_board_render.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_render.sv
// Connect-4 board renderer: pixel counters -> slot read address -> RGB for any COLS x ROWS grid.
// Latency: slot_addr 1 cycle after the pixel, RGB/de_out 2 cycles; slot_state/slot_win consumed 1 cycle after slot_addr.
// Backpressure: none; accepts one pixel per clock and never stalls.
module vga_board_render #(
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int ADDR_W       = 6,
    parameter int PITCH        = 60,
    parameter int RADIUS       = 15,
    parameter int BOARD_X0     = 110,
    parameter int BOARD_Y0     = 80,
    parameter int HOVER_Y      = 55,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    input  logic              in_display_area,
    input  logic [9:0]        select_x,
    input  logic [1:0]        player_turn,
    input  logic              win_blink_en,
    output logic [ADDR_W-1:0] slot_addr,
    input  logic [1:0]        slot_state,
    input  logic              slot_win,
    output logic              de_out,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b
);
    localparam int BOARD_X1 = BOARD_X0 + COLS * PITCH;
    localparam int BOARD_Y1 = BOARD_Y0 + ROWS * PITCH;
    localparam int HALF     = PITCH / 2;
    localparam int R_SQ     = RADIUS * RADIUS;
    localparam int FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic                w_in_board;
    logic                w_in_hole;
    logic                w_in_hover;
    logic                w_frame_start;
    logic [9:0]          w_rel_x;
    logic [9:0]          w_rel_y;
    logic [9:0]          w_rem_x;
    logic [9:0]          w_rem_y;
    logic [ADDR_W-1:0]   w_col;
    logic [ADDR_W-1:0]   w_row;
    logic [ADDR_W-1:0]   w_addr;
    logic signed [11:0]  w_dx;
    logic signed [11:0]  w_dy;
    logic signed [11:0]  w_hx;
    logic signed [11:0]  w_hy;
    logic signed [23:0]  w_cell_d2;
    logic signed [23:0]  w_hover_d2;
    logic [2:0]          w_rgb;

    logic                r_in_board;
    logic                r_in_hole;
    logic                r_in_hover;
    logic                r_de;
    logic [1:0]          r_turn;
    logic [FCW-1:0]      r_frame_cnt;
    logic                r_blink_phase;

    // Stage-1 geometry: board window, cell coordinates, hole and selector circle tests
    always_comb begin
        w_in_board = ({1'b0, counter_x} >= 11'(BOARD_X0)) && ({1'b0, counter_x} < 11'(BOARD_X1)) &&
                     ({1'b0, counter_y} >= 11'(BOARD_Y0)) && ({1'b0, counter_y} < 11'(BOARD_Y1));
        w_rel_x    = counter_x - 10'(BOARD_X0);
        w_rel_y    = counter_y - 10'(BOARD_Y0);
        w_rem_x    = w_rel_x % 10'(PITCH);
        w_rem_y    = w_rel_y % 10'(PITCH);
        w_col      = ADDR_W'(w_rel_x / 10'(PITCH));
        // row 0 is the bottom row, so flip the band index counted from the top edge
        w_row      = ADDR_W'(ROWS - 1) - ADDR_W'(w_rel_y / 10'(PITCH));
        w_addr     = w_col * ADDR_W'(ROWS) + w_row;
        w_dx       = $signed({2'b00, w_rem_x}) - $signed(12'(HALF));
        w_dy       = $signed({2'b00, w_rem_y}) - $signed(12'(HALF));
        w_cell_d2  = 24'(w_dx) * 24'(w_dx) + 24'(w_dy) * 24'(w_dy);
        w_in_hole  = w_in_board && (w_cell_d2 <= $signed(24'(R_SQ)));
        // 12-bit signed deltas keep a selector near x=0 from wrapping onto the right edge
        w_hx       = $signed({2'b00, counter_x}) - $signed({2'b00, select_x});
        w_hy       = $signed({2'b00, counter_y}) - $signed(12'(HOVER_Y));
        w_hover_d2 = 24'(w_hx) * 24'(w_hx) + 24'(w_hy) * 24'(w_hy);
        w_in_hover = (w_hover_d2 <= $signed(24'(R_SQ)));
        w_frame_start = (counter_x == 10'd0) && (counter_y == 10'd0);
    end

    // Stage-1 registers; slot_addr only follows the beam while it is over the board
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_board <= 1'b0;
            r_in_hole  <= 1'b0;
            r_in_hover <= 1'b0;
            r_de       <= 1'b0;
            r_turn     <= 2'd0;
            slot_addr  <= '0;
        end else begin
            r_in_board <= w_in_board;
            r_in_hole  <= w_in_hole;
            r_in_hover <= w_in_hover;
            r_de       <= in_display_area;
            r_turn     <= player_turn;
            if (w_in_board) begin
                slot_addr <= w_addr;
            end
        end
    end

    // Frame counter and blink phase; disabling blink parks both at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!win_blink_en) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Stage-2 colour priority: blanking, hole contents, board face, selector piece
    always_comb begin
        w_rgb = 3'b000;
        if (!r_de) begin
            w_rgb = 3'b000;
        end else if (r_in_hole) begin
            case (slot_state)
                2'd1:    w_rgb = 3'b100;
                2'd2:    w_rgb = 3'b010;
                default: w_rgb = 3'b000;
            endcase
            if (win_blink_en && slot_win && r_blink_phase) begin
                w_rgb = 3'b000;
            end
        end else if (r_in_board) begin
            w_rgb = 3'b110;
        end else if (r_in_hover) begin
            case (r_turn)
                2'd1:    w_rgb = 3'b100;
                2'd2:    w_rgb = 3'b010;
                default: w_rgb = 3'b000;
            endcase
        end
    end

    // Stage-2 output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out <= 1'b0;
            vga_r  <= 1'b0;
            vga_g  <= 1'b0;
            vga_b  <= 1'b0;
        end else begin
            de_out <= r_de;
            vga_r  <= w_rgb[2];
            vga_g  <= w_rgb[1];
            vga_b  <= w_rgb[0];
        end
    end
endmodule

// File: tb/tb_vga_board_render.sv
// Bench for vga_board_render: directed vector table, blink/reset sequences, randomized scoreboard run.
// Latency: expects slot_addr 1 cycle and RGB/de_out 2 cycles after each pixel.
// Backpressure: none; drives one pixel per clock.
module tb_vga_board_render;
    localparam int COLS = 7, ROWS = 6, PITCH = 60, RADIUS = 15;
    localparam int BX0 = 110, BY0 = 80, HY = 55, BF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] counter_x = '0;
    logic [9:0] counter_y = '0;
    logic       in_display_area = 1'b0;
    logic [9:0] select_x = '0;
    logic [1:0] player_turn = '0;
    logic       win_blink_en = 1'b0;
    logic [1:0] slot_state = '0;
    logic       slot_win = 1'b0;
    logic [5:0] slot_addr, slot_addr8;
    logic       de_out, vga_r, vga_g, vga_b;
    logic       de_out8, vga_r8, vga_g8, vga_b8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_board_render #(.BLINK_FRAMES(BF)) u_dut (
        .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
        .in_display_area(in_display_area), .select_x(select_x), .player_turn(player_turn),
        .win_blink_en(win_blink_en), .slot_addr(slot_addr), .slot_state(slot_state),
        .slot_win(slot_win), .de_out(de_out), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_board_render #(.COLS(8), .ROWS(7), .ADDR_W(6)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
        .in_display_area(in_display_area), .select_x(select_x), .player_turn(player_turn),
        .win_blink_en(win_blink_en), .slot_addr(slot_addr8), .slot_state(slot_state),
        .slot_win(slot_win), .de_out(de_out8), .vga_r(vga_r8), .vga_g(vga_g8), .vga_b(vga_b8)
    );

    typedef struct {
        string nm;
        int    x, y;
        bit    de;
        int    sx, turn, st;
        int    exp_addr, exp_rgb;
        bit    exp_de;
    } vec_t;

    typedef struct {
        bit de, board, hole, hover;
        int turn, addr;
    } pix_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rgb();
        return int'({vga_r, vga_g, vga_b});
    endfunction

    // One pixel followed by a parked off-board pixel; checks address then colour
    task automatic pix(input string nm, input int x, input int y, input bit de, input int sx,
                       input int turn, input int st, input bit win, input int exp_addr,
                       input int exp_rgb, input bit exp_de);
        counter_x = 10'(x); counter_y = 10'(y); in_display_area = de;
        select_x = 10'(sx); player_turn = 2'(turn);
        tick();
        chk({nm, " addr"}, int'(slot_addr), exp_addr);
        slot_state = 2'(st); slot_win = win;
        counter_x = 10'd1000; counter_y = 10'd1000; in_display_area = 1'b0;
        tick();
        chk({nm, " rgb"}, rgb(), exp_rgb);
        chk({nm, " de"}, int'(de_out), int'(exp_de));
    endtask

    task automatic frame_start();
        counter_x = 10'd0; counter_y = 10'd0; in_display_area = 1'b0;
        tick();
    endtask

    // Reference: locate the pixel by cell centre and plain distance arithmetic
    function automatic pix_t analyze(int x, int y, bit de, int sx, int turn);
        pix_t p;
        int col, band, cx, cy;
        p.de    = de;
        p.turn  = turn;
        p.board = (x >= BX0) && (x < BX0 + COLS * PITCH) && (y >= BY0) && (y < BY0 + ROWS * PITCH);
        col  = (x - BX0) / PITCH;
        band = (y - BY0) / PITCH;
        cx   = BX0 + col * PITCH + PITCH / 2;
        cy   = BY0 + band * PITCH + PITCH / 2;
        p.hole  = p.board && ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= RADIUS * RADIUS);
        p.hover = ((x - sx) * (x - sx) + (y - HY) * (y - HY)) <= RADIUS * RADIUS;
        p.addr  = col * ROWS + (ROWS - 1 - band);
        return p;
    endfunction

    function automatic int colour(pix_t p, int st, bit win, bit en, bit ph);
        if (!p.de) return 0;
        if (p.hole) begin
            if (en && win && ph) return 0;
            return (st == 1) ? 4 : (st == 2) ? 2 : 0;
        end
        if (p.board) return 6;
        if (p.hover) return (p.turn == 1) ? 4 : (p.turn == 2) ? 2 : 0;
        return 0;
    endfunction

    vec_t vt[16];
    logic [1:0] board_st[64];
    bit         board_win[64];

    initial begin
        vt[0]  = '{"red_c0r0",   140, 410, 1, 320, 0, 1,  0, 4, 1};
        vt[1]  = '{"grn_41",     500, 110, 1, 320, 0, 2, 41, 2, 1};
        vt[2]  = '{"hole_edge",  155, 410, 1, 320, 0, 0,  0, 0, 1};
        vt[3]  = '{"rim_yel",    156, 410, 1, 320, 0, 1,  0, 6, 1};
        vt[4]  = '{"hov_grn",    320,  55, 1, 320, 2, 1,  0, 2, 1};
        vt[5]  = '{"hov_none",   320,  55, 1, 320, 0, 1,  0, 0, 1};
        vt[6]  = '{"hov_out",    336,  55, 1, 320, 1, 1,  0, 0, 1};
        vt[7]  = '{"hov_rim",    335,  55, 1, 320, 1, 1,  0, 4, 1};
        vt[8]  = '{"de_low",     140, 410, 0, 320, 0, 1,  0, 0, 0};
        vt[9]  = '{"sel_left",     5,  55, 1,   3, 2, 0,  0, 2, 1};
        vt[10] = '{"no_wrap",   1020,  55, 1,   3, 2, 0,  0, 0, 1};
        vt[11] = '{"corner",     529, 439, 1, 320, 0, 2, 36, 6, 1};
        vt[12] = '{"off_right",  530, 439, 1, 320, 0, 2, 36, 0, 1};
        vt[13] = '{"top_row",    140,  80, 1, 320, 0, 1,  5, 6, 1};
        vt[14] = '{"hole_34",    440, 170, 1, 320, 0, 2, 34, 2, 1};
        vt[15] = '{"st3_black",  440, 170, 1, 320, 0, 3, 34, 0, 1};

        // reset state
        counter_x = 10'd1000; counter_y = 10'd1000;
        repeat (3) tick();
        chk("rst rgb", rgb(), 0);
        chk("rst de", int'(de_out), 0);
        chk("rst addr", int'(slot_addr), 0);
        rst_n = 1'b1;
        tick();

        foreach (vt[i])
            pix(vt[i].nm, vt[i].x, vt[i].y, vt[i].de, vt[i].sx, vt[i].turn, vt[i].st, 1'b0,
                vt[i].exp_addr, vt[i].exp_rgb, vt[i].exp_de);

        // 8x7 build: far column/row addressing
        counter_x = 10'd560; counter_y = 10'd440; in_display_area = 1'b1;
        tick();
        chk("b8 addr49", int'(slot_addr8), 49);
        counter_x = 10'd110; counter_y = 10'd80;
        tick();
        chk("b8 addr6", int'(slot_addr8), 6);
        chk("b8 rgb", int'({vga_r8, vga_g8, vga_b8}), 6);
        chk("b8 de", int'(de_out8), 1);

        // blinking winning piece: two frames on, two off
        win_blink_en = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) begin
            pix($sformatf("blink_f%0d", f), 140, 410, 1, 320, 0, 1, 1, 0,
                (f == 2 || f == 3) ? 0 : 4, 1);
            frame_start();
        end
        frame_start();
        pix("blink_f6", 140, 410, 1, 320, 0, 1, 1, 0, 0, 1);
        win_blink_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            pix($sformatf("steady_%0d", f), 140, 410, 1, 320, 0, 1, 1, 0, 4, 1);
            frame_start();
        end

        // async reset mid-line, refill latency, blink phase restart
        win_blink_en = 1'b1;
        tick();
        frame_start();
        frame_start();
        counter_x = 10'd140; counter_y = 10'd410; in_display_area = 1'b1;
        slot_state = 2'd1; slot_win = 1'b0;
        repeat (3) tick();
        chk("pre_rst rgb", rgb(), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rgb", rgb(), 0);
        chk("async rst de", int'(de_out), 0);
        slot_win = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("refill1 rgb", rgb(), 0);
        chk("refill1 de", int'(de_out), 0);
        tick();
        chk("refill2 rgb", rgb(), 4);
        chk("refill2 de", int'(de_out), 1);

        // randomized run against the reference model
        foreach (board_st[i]) begin
            board_st[i]  = 2'($urandom_range(0, 3));
            board_win[i] = 1'($urandom_range(0, 1));
        end
        counter_x = 10'd1000; counter_y = 10'd1000; in_display_area = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        begin
            pix_t p1, pn;
            int   m_addr, n_fs, x, y, sx, mode, exp_rgb, exp_de;
            bit   en, de;
            p1 = '{0, 0, 0, 0, 0, 0};
            m_addr = 0; n_fs = 0; en = 1'b1;
            slot_state = board_st[0]; slot_win = board_win[0];
            for (int c = 0; c < 4000; c++) begin
                mode = $urandom_range(0, 9);
                sx = $urandom_range(0, 700);
                if (mode == 0) begin
                    x = 0; y = 0;
                end else if (mode <= 3) begin
                    x = sx + $urandom_range(0, 40) - 20;
                    if (x < 0) x = 0;
                    y = HY + $urandom_range(0, 40) - 20;
                end else begin
                    x = $urandom_range(0, 700);
                    y = $urandom_range(0, 520);
                end
                de = ($urandom_range(0, 9) != 0);
                if (en) en = ($urandom_range(0, 49) != 0);
                else    en = ($urandom_range(0, 4) == 0);
                counter_x = 10'(x); counter_y = 10'(y); in_display_area = de;
                select_x = 10'(sx); player_turn = 2'($urandom_range(0, 3));
                win_blink_en = en;
                exp_rgb = colour(p1, int'(slot_state), slot_win, en, 1'((n_fs / BF) % 2));
                exp_de  = int'(p1.de);
                pn = analyze(x, y, de, sx, int'(player_turn));
                if (pn.board) m_addr = pn.addr;
                if (!en) n_fs = 0;
                else if (x == 0 && y == 0) n_fs++;
                p1 = pn;
                tick();
                chk($sformatf("rand%0d rgb", c), rgb(), exp_rgb);
                chk($sformatf("rand%0d de", c), int'(de_out), exp_de);
                chk($sformatf("rand%0d addr", c), int'(slot_addr), m_addr);
                slot_state = board_st[m_addr];
                slot_win   = board_win[m_addr];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
